// File: rtl/sprite_position_scheduler_if.sv
// Requester-side write port of the sprite position scheduler.
// All requesters share one bundle. Each requester owns one bit of req_valid
// and one slot of each data array. The scheduler answers with a one-hot
// req_ready grant.
interface sprite_position_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0][IDW-1:0] req_id;
  logic [NUM_REQ-1:0][10:0]    req_row;
  logic [NUM_REQ-1:0][11:0]    req_col;
  logic [NUM_REQ-1:0]          req_ready;

  modport master (output req_valid, req_id, req_row, req_col, input req_ready);
  modport slave  (input req_valid, req_id, req_row, req_col, output req_ready);
endinterface

// File: rtl/sprite_position_scheduler.sv
// Double-buffered sprite position table.
// Requesters write a shadow table through a round-robin arbitrated port.
// On vblank_start, a sequenced commit copies every dirty shadow entry into
// the active table, one sprite per cycle.
// Optional feature macro: SPRITE_CLAMP_EN. When it is defined, coordinates
// are clamped to the visible area (row <= 1199, col <= 1599) as they are
// written to the shadow table.
module sprite_position_scheduler #(
  parameter int SPRITES = 4,
  parameter int NUM_REQ = 2,
  parameter int IDW     = (SPRITES > 1) ? $clog2(SPRITES) : 1
) (
  input  logic                      clock_162,
  input  logic                      rst,
  input  logic                      vblank_start,
  sprite_position_scheduler_if.slave req_if,
  output logic [SPRITES-1:0][10:0]  sprite_row,
  output logic [SPRITES-1:0][11:0]  sprite_col,
  output logic                      commit_done,
  output logic [15:0]               frame_count,
  output logic                      overrun,
  output logic                      bad_id
);

  localparam int IXW = (SPRITES > 1) ? $clog2(SPRITES) : 1;
  localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IXW-1:0] LAST_IDX = IXW'(SPRITES - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [IXW-1:0]           idx_q, idx_d;
  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic                     done_q, done_d;
  logic [15:0]              frame_q, frame_d;
  logic                     overrun_q, overrun_d;
  logic                     bad_id_q;
  logic [SPRITES-1:0][10:0] shadow_row_q, active_row_q;
  logic [SPRITES-1:0][11:0] shadow_col_q, active_col_q;
  logic [SPRITES-1:0]       dirty_q;

  logic                     grant_any_s;
  logic [PW-1:0]            grant_idx_s;
  logic [PW-1:0]            cand_s;
  logic [NUM_REQ-1:0]       grant_s;
  logic [IDW-1:0]           sel_id_s;
  logic [10:0]              sel_row_s;
  logic [11:0]              sel_col_s;
  logic                     sel_ok_s;

`ifdef SPRITE_CLAMP_EN
  function automatic logic [10:0] clamp_row(input logic [10:0] r);
    clamp_row = (r > 11'd1199) ? 11'd1199 : r;
  endfunction

  function automatic logic [11:0] clamp_col(input logic [11:0] c);
    clamp_col = (c > 12'd1599) ? 12'd1599 : c;
  endfunction
`else
  function automatic logic [10:0] clamp_row(input logic [10:0] r);
    clamp_row = r;
  endfunction

  function automatic logic [11:0] clamp_col(input logic [11:0] c);
    clamp_col = c;
  endfunction
`endif

  // Round-robin search. Find the first valid requester at or after rr_ptr.
  // Only IDLE cycles without a vblank_start are eligible for a grant.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    if (!rst && (state_q == ST_IDLE) && !vblank_start) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand_s = PW'((int'(rr_ptr_q) + i) % NUM_REQ);
        if (!grant_any_s && req_if.req_valid[cand_s]) begin
          grant_any_s = 1'b1;
          grant_idx_s = cand_s;
        end
      end
    end else begin
      grant_any_s = 1'b0;
    end
  end

  // Expand the grant into the one-hot ready vector.
  always_comb begin
    grant_s = '0;
    if (grant_any_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign req_if.req_ready = grant_s;

  // Mux the granted requester's payload and check that its id is in range.
  always_comb begin
    sel_id_s  = req_if.req_id[grant_idx_s];
    sel_row_s = clamp_row(req_if.req_row[grant_idx_s]);
    sel_col_s = clamp_col(req_if.req_col[grant_idx_s]);
    sel_ok_s  = (int'(sel_id_s) < SPRITES);
  end

  // Advance the pointer past the winner. Hold it when nothing is granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any_s) begin
      rr_ptr_d = PW'((int'(grant_idx_s) + 1) % NUM_REQ);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Commit sequencer next state: walk idx across every sprite, then return to IDLE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    frame_d   = frame_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (vblank_start) begin
          state_d = ST_COMMIT;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        if (vblank_start) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
          frame_d = frame_q + 16'd1;
        end else begin
          idx_d = idx_q + IXW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Control registers: FSM state, commit index, arbiter pointer and status flags.
  always_ff @(posedge clock_162) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      done_q    <= 1'b0;
      frame_q   <= 16'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      done_q    <= done_d;
      frame_q   <= frame_d;
      overrun_q <= overrun_d;
    end
  end

  // Tables. Shadow writes happen only in IDLE. Shadow-to-active copies
  // happen only in COMMIT. The two therefore never collide on dirty_q.
  always_ff @(posedge clock_162) begin
    if (rst) begin
      shadow_row_q <= '0;
      shadow_col_q <= '0;
      active_row_q <= '0;
      active_col_q <= '0;
      dirty_q      <= '0;
      bad_id_q     <= 1'b0;
    end else begin
      if (grant_any_s) begin
        if (sel_ok_s) begin
          for (int k = 0; k < SPRITES; k++) begin
            if (int'(sel_id_s) == k) begin
              shadow_row_q[k] <= sel_row_s;
              shadow_col_q[k] <= sel_col_s;
              dirty_q[k]      <= 1'b1;
            end
          end
        end else begin
          bad_id_q <= 1'b1;
        end
      end
      if (state_q == ST_COMMIT) begin
        for (int k = 0; k < SPRITES; k++) begin
          if ((int'(idx_q) == k) && dirty_q[k]) begin
            active_row_q[k] <= shadow_row_q[k];
            active_col_q[k] <= shadow_col_q[k];
            dirty_q[k]      <= 1'b0;
          end
        end
      end
    end
  end

  assign sprite_row  = active_row_q;
  assign sprite_col  = active_col_q;
  assign commit_done = done_q;
  assign frame_count = frame_q;
  assign overrun     = overrun_q;
  assign bad_id      = bad_id_q;

endmodule

// File: tb/tb_sprite_position_scheduler.sv
// Self-checking bench for sprite_position_scheduler (SPRITES=4, NUM_REQ=2, IDW=3).
// A frame-level reference model tracks the shadow and active tables, the
// commit window and the status flags. Directed scenarios run first,
// followed by a randomized soak.
module tb_sprite_position_scheduler;

  localparam int S  = 4;
  localparam int NR = 2;
  localparam int IW = 3;

  logic clk;
  logic rst;
  logic vblank;
  logic [S-1:0][10:0] sprite_row;
  logic [S-1:0][11:0] sprite_col;
  logic               commit_done;
  logic [15:0]        frame_count;
  logic               overrun;
  logic               bad_id;

  sprite_position_scheduler_if #(.NUM_REQ(NR), .IDW(IW)) bus ();

  sprite_position_scheduler #(.SPRITES(S), .NUM_REQ(NR), .IDW(IW)) dut (
    .clock_162   (clk),
    .rst         (rst),
    .vblank_start(vblank),
    .req_if      (bus.slave),
    .sprite_row  (sprite_row),
    .sprite_col  (sprite_col),
    .commit_done (commit_done),
    .frame_count (frame_count),
    .overrun     (overrun),
    .bad_id      (bad_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // reference model state
  int sh_row [8];
  int sh_col [8];
  int act_row [S];
  int act_col [S];
  int p_m;
  int cyc;
  int v0;
  int fc_m;
  bit ovr_m;
  bit bad_m;

  function automatic int clamp_r(int r);
`ifdef SPRITE_CLAMP_EN
    return (r > 1199) ? 1199 : r;
`else
    return r;
`endif
  endfunction

  function automatic int clamp_c(int c);
`ifdef SPRITE_CLAMP_EN
    return (c > 1599) ? 1599 : c;
`else
    return c;
`endif
  endfunction

  function automatic bit in_commit();
    return (cyc > v0) && (cyc <= v0 + S);
  endfunction

  function automatic logic [NR-1:0] predict_ready();
    logic [NR-1:0] g;
    int r;
    g = '0;
    if (rst || in_commit() || vblank) return g;
    for (int off = 0; off < NR; off++) begin
      r = (p_m + off) % NR;
      if (bus.req_valid[r]) begin
        g[r] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic logic [S-1:0][10:0] exp_rows();
    logic [S-1:0][10:0] v;
    for (int k = 0; k < S; k++) v[k] = 11'(act_row[k]);
    return v;
  endfunction

  function automatic logic [S-1:0][11:0] exp_cols();
    logic [S-1:0][11:0] v;
    for (int k = 0; k < S; k++) v[k] = 12'(act_col[k]);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin sh_row[k] = 0; sh_col[k] = 0; end
    for (int k = 0; k < S; k++) begin act_row[k] = 0; act_col[k] = 0; end
    p_m = 0; v0 = -100; fc_m = 0; ovr_m = 0; bad_m = 0;
  endtask

  // Apply one clock edge's worth of behaviour to the model, then clock the DUT.
  task automatic advance();
    logic [NR-1:0] g;
    bit ic;
    int id;
    int k;
    g  = predict_ready();
    ic = in_commit();
    if (rst) begin
      model_reset();
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (g[r]) begin
          id = int'(bus.req_id[r]);
          if (id < S) begin
            sh_row[id] = clamp_r(int'(bus.req_row[r]));
            sh_col[id] = clamp_c(int'(bus.req_col[r]));
          end else begin
            bad_m = 1;
          end
          p_m = (r + 1) % NR;
        end
      end
      if (ic) begin
        k = cyc - v0 - 1;
        act_row[k] = sh_row[k];
        act_col[k] = sh_col[k];
        if (k == S - 1) fc_m = (fc_m + 1) % 65536;
      end
      if (vblank) begin
        if (ic) ovr_m = 1;
        else v0 = cyc;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int r, bit v, int id, int row, int col);
    bus.req_valid[r] = v;
    bus.req_id[r]    = IW'(id);
    bus.req_row[r]   = 11'(row);
    bus.req_col[r]   = 12'(col);
  endtask

  task automatic pulse_vblank_and_wait();
    vblank = 1'b1;
    advance();
    vblank = 1'b0;
    repeat (S + 1) advance();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b1, 0, 5, 5);
    set_req(1, 1'b1, 1, 6, 6);
    #1;
    n_cmp++;
    if (bus.req_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready);
    end
    advance();
    advance();
    rst = 1'b0;
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    #1;
    n_cmp++;
    if (sprite_row !== '0 || sprite_col !== '0) begin
      n_fail++; $display("FAIL reset_pos got=%h/%h exp=0", sprite_row, sprite_col);
    end
    n_cmp++;
    if ({frame_count, overrun, bad_id, commit_done, bus.req_ready} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_flags got fc=%0d ovr=%b bad=%b done=%b rdy=%b exp all 0",
               frame_count, overrun, bad_id, commit_done, bus.req_ready);
    end
  endtask

  task automatic test_single_write();
    int v;
    set_req(0, 1'b1, 1, 300, 800);
    #1;
    n_cmp++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL single_grant got=%b exp=01", bus.req_ready);
    end
    advance();
    set_req(0, 1'b0, 0, 0, 0);
    repeat (3) begin
      n_cmp++;
      if (sprite_row[1] !== 11'd0) begin
        n_fail++; $display("FAIL single_pre_commit got=%0d exp=0", sprite_row[1]);
      end
      advance();
    end
    vblank = 1'b1;
    v = cyc;
    advance();
    vblank = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      n_cmp++;
      if (sprite_row[1] !== ((c >= 3) ? 11'd300 : 11'd0) ||
          sprite_col[1] !== ((c >= 3) ? 12'd800 : 12'd0)) begin
        n_fail++;
        $display("FAIL single_commit_timing v+%0d got=%0d/%0d exp=%0d", c,
                 sprite_row[1], sprite_col[1], (c >= 3) ? 300 : 0);
      end
      n_cmp++;
      if (commit_done !== (c == S + 1)) begin
        n_fail++; $display("FAIL single_done v+%0d got=%b exp=%b", c, commit_done, c == S + 1);
      end
      if (c == S + 1) begin
        n_cmp++;
        if (frame_count !== 16'd1) begin
          n_fail++; $display("FAIL single_frame_count got=%0d exp=1", frame_count);
        end
      end
      advance();
    end
    if (cyc - v != 7) $display("note: cycle bookkeeping drift %0d", cyc - v);
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    // pointer sits at 1 after the previous test: a lone req1 write moves it back to 0
    set_req(1, 1'b1, 2, 10, 7);
    #1;
    n_cmp++;
    if (bus.req_ready !== 2'b10) begin
      n_fail++; $display("FAIL rr_setup got=%b exp=10", bus.req_ready);
    end
    advance();
    set_req(0, 1'b1, 0, 100, 1);
    set_req(1, 1'b1, 2, 20, 2);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (bus.req_ready !== exp_g[i]) begin
        n_fail++; $display("FAIL rr_alternate i=%0d got=%b exp=%b", i, bus.req_ready, exp_g[i]);
      end
      advance();
    end
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    pulse_vblank_and_wait();
    n_cmp++;
    if (sprite_row[2] !== 11'd20 || sprite_row[0] !== 11'd100) begin
      n_fail++;
      $display("FAIL rr_last_write_wins got row2=%0d row0=%0d exp=20/100", sprite_row[2], sprite_row[0]);
    end
  endtask

  task automatic test_vblank_block();
    set_req(0, 1'b1, 3, 55, 66);
    vblank = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 2'b00) begin
      n_fail++; $display("FAIL block_vblank_cycle got=%b exp=00", bus.req_ready);
    end
    advance();
    vblank = 1'b0;
    for (int c = 1; c <= S; c++) begin
      #1;
      n_cmp++;
      if (bus.req_ready !== 2'b00) begin
        n_fail++; $display("FAIL block_commit v+%0d got=%b exp=00", c, bus.req_ready);
      end
      advance();
    end
    #1;
    n_cmp++;
    if (bus.req_ready !== 2'b01 || commit_done !== 1'b1) begin
      n_fail++; $display("FAIL block_first_idle got rdy=%b done=%b exp=01/1", bus.req_ready, commit_done);
    end
    advance();
    set_req(0, 1'b0, 0, 0, 0);
    n_cmp++;
    if (sprite_row[3] !== 11'd0) begin
      n_fail++; $display("FAIL block_not_yet_visible got=%0d exp=0", sprite_row[3]);
    end
    pulse_vblank_and_wait();
    n_cmp++;
    if (sprite_row[3] !== 11'd55 || sprite_col[3] !== 12'd66) begin
      n_fail++; $display("FAIL block_next_frame got=%0d/%0d exp=55/66", sprite_row[3], sprite_col[3]);
    end
  endtask

  task automatic test_overrun_bad_id();
    logic [S-1:0][10:0] keep_r;
    logic [S-1:0][11:0] keep_c;
    vblank = 1'b1;
    advance();
    vblank = 1'b0;
    advance();
    vblank = 1'b1;
    #1;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_before got=%b exp=0", overrun);
    end
    advance();
    vblank = 1'b0;
    for (int c = 3; c <= S + 1; c++) begin
      n_cmp++;
      if (overrun !== 1'b1 || commit_done !== (c == S + 1)) begin
        n_fail++; $display("FAIL overrun_seq v+%0d got ovr=%b done=%b exp=1/%b", c, overrun, commit_done, c == S + 1);
      end
      if (c == S + 1) begin
        n_cmp++;
        if (frame_count !== 16'(fc_m)) begin
          n_fail++; $display("FAIL overrun_frame_count got=%0d exp=%0d", frame_count, fc_m);
        end
      end
      advance();
    end
    keep_r = exp_rows();
    keep_c = exp_cols();
    set_req(0, 1'b1, 7, 999, 999);
    #1;
    n_cmp++;
    if (bus.req_ready !== predict_ready() || bus.req_ready === 2'b00) begin
      n_fail++; $display("FAIL bad_id_grant got=%b exp=%b", bus.req_ready, predict_ready());
    end
    advance();
    set_req(0, 1'b0, 0, 0, 0);
    n_cmp++;
    if (bad_id !== 1'b1) begin
      n_fail++; $display("FAIL bad_id_flag got=%b exp=1", bad_id);
    end
    pulse_vblank_and_wait();
    n_cmp++;
    if (sprite_row !== keep_r || sprite_col !== keep_c) begin
      n_fail++; $display("FAIL bad_id_no_change got=%h/%h exp=%h/%h", sprite_row, sprite_col, keep_r, keep_c);
    end
  endtask

  task automatic test_clamp();
    set_req(0, 1'b1, 0, 1500, 4000);
    #1;
    n_cmp++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL clamp_grant got=%b exp=01", bus.req_ready);
    end
    advance();
    set_req(0, 1'b0, 0, 0, 0);
    pulse_vblank_and_wait();
    n_cmp++;
`ifdef SPRITE_CLAMP_EN
    if (sprite_row[0] !== 11'd1199 || sprite_col[0] !== 12'd1599) begin
      n_fail++; $display("FAIL clamp_value got=%0d/%0d exp=1199/1599", sprite_row[0], sprite_col[0]);
    end
`else
    if (sprite_row[0] !== 11'd1500 || sprite_col[0] !== 12'd4000) begin
      n_fail++; $display("FAIL clamp_value got=%0d/%0d exp=1500/4000", sprite_row[0], sprite_col[0]);
    end
`endif
  endtask

  task automatic test_random();
    logic [NR-1:0] g;
    for (int t = 0; t < 3000; t++) begin
      rst    = ($urandom_range(0, 399) == 0);
      vblank = ($urandom_range(0, 9) == 0);
      for (int r = 0; r < NR; r++) begin
        if (!bus.req_valid[r] && $urandom_range(0, 2) == 0) begin
          bus.req_valid[r] = 1'b1;
          bus.req_id[r]    = IW'($urandom_range(0, 4));
          bus.req_row[r]   = 11'($urandom);
          bus.req_col[r]   = 12'($urandom);
        end
      end
      #1;
      g = predict_ready();
      n_cmp++;
      if (bus.req_ready !== g) begin
        n_fail++; $display("FAIL rand_ready t=%0d got=%b exp=%b", t, bus.req_ready, g);
      end
      n_cmp++;
      if (sprite_row !== exp_rows() || sprite_col !== exp_cols()) begin
        n_fail++; $display("FAIL rand_pos t=%0d got=%h/%h exp=%h/%h", t, sprite_row, sprite_col, exp_rows(), exp_cols());
      end
      n_cmp++;
      if (commit_done !== (cyc == v0 + S + 1) || frame_count !== 16'(fc_m) ||
          overrun !== ovr_m || bad_id !== bad_m) begin
        n_fail++;
        $display("FAIL rand_status t=%0d got done=%b fc=%0d ovr=%b bad=%b exp %b/%0d/%b/%b", t,
                 commit_done, frame_count, overrun, bad_id, cyc == v0 + S + 1, fc_m, ovr_m, bad_m);
      end
      advance();
      for (int r = 0; r < NR; r++) begin
        if (g[r]) bus.req_valid[r] = 1'b0;
      end
    end
    rst = 1'b0;
    vblank = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    rst = 1'b1;
    vblank = 1'b0;
    bus.req_valid = '0;
    bus.req_id = '0;
    bus.req_row = '0;
    bus.req_col = '0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_vblank_block();
    test_overrun_bad_id();
    test_clamp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_position_scheduler.md
# sprite_position_scheduler

Double-buffered sprite-position controller in front of the VGA driver. Physics requesters write new sprite coordinates into a shadow table through a round-robin-arbitrated valid/ready port. A sequenced commit copies the shadow table into the active table at the start of vertical blanking. The display sees positions change only between frames: no tearing, no mid-frame sprite jumps.

## Interface
- SPRITES, default 4: number of sprites, 1..16.
- NUM_REQ, default 2: number of write requesters, 1..8.
- IDW, default $clog2(SPRITES), minimum 1: sprite-id width.

- clock_162, input, 1: pixel clock, 162 MHz.
- rst, input, 1: reset, synchronous, active-high.
- vblank_start, input, 1: one-cycle pulse on the cycle the display counters wrap to row 0, col 0.
- req_valid, input, [NUM_REQ-1:0]: per-requester write request.
- req_id, input, [NUM_REQ-1:0][IDW-1:0]: target sprite per requester.
- req_row, input, [NUM_REQ-1:0][10:0]: new row per requester.
- req_col, input, [NUM_REQ-1:0][11:0]: new column per requester.
- req_ready, output, [NUM_REQ-1:0]: one-hot grant; a write transfers when valid and ready are both high.
- sprite_row, output, [SPRITES-1:0][10:0]: active rows, fed to the driver.
- sprite_col, output, [SPRITES-1:0][11:0]: active columns, fed to the driver.
- commit_done, output, 1: one-cycle pulse after a commit finishes.
- frame_count, output, 16: number of completed commits, wraps.
- overrun, output, 1: sticky flag; a vblank_start arrived during COMMIT.
- bad_id, output, 1: sticky flag; a write targeted an id >= SPRITES.

## Operation
- **State machine:** two states, IDLE and COMMIT.
  - IDLE -> COMMIT when vblank_start = 1; idx <= 0.
  - In COMMIT, each cycle: if dirty[idx], copy shadow[idx] to active[idx] and clear dirty[idx]; then idx++.
  - When idx = SPRITES-1 is processed, go to IDLE. commit_done pulses in the first IDLE cycle and frame_count increments in that cycle.
- **Arbitration (IDLE, vblank_start = 0 only):**
  - Grant the first valid requester at or after rr_ptr, cyclically.
  - req_ready is combinational from req_valid and state; at most one bit is high.
  - On a transfer: shadow[id] <= {row, col}, dirty[id] <= 1, rr_ptr <= (granted+1) mod NUM_REQ.
  - rr_ptr is unchanged when nothing is granted.
- **Blocking:** req_ready = 0 in every COMMIT cycle and in any cycle with vblank_start = 1. Requesters hold valid and data stable until granted.
- **Repeated writes:** multiple writes to the same sprite within one frame are last-write-wins.
- **Bad id:** a write with id >= SPRITES is still granted (ready = 1), its data is discarded, and bad_id is set.
- **Overrun:** vblank_start during COMMIT is ignored for sequencing and sets overrun.
- **Active table** changes only during COMMIT; sprites that are not dirty keep their previous position.
- **Reset values:** shadow, active, dirty, rr_ptr, idx, frame_count = 0; state = IDLE; all outputs 0, including req_ready, commit_done, overrun and bad_id.
- **Reset mid-COMMIT:** the commit is abandoned, all tables return to 0, and no commit_done pulse is produced.

## Timing
- Write accepted at cycle t: visible in shadow at t+1; visible on sprite_row/col after the next commit that starts after t.
- Commit starts with vblank_start at cycle v:
  - active[k] updates at the clock edge ending cycle v+1+k;
  - COMMIT occupies cycles v+1..v+SPRITES;
  - commit_done is high in cycle v+SPRITES+1.
- Requester stall per frame: SPRITES+1 cycles. This is negligible against the 50-line blanking interval (108000 cycles).
- Outputs are registered; no combinational path from req_* to sprite_row/col.

## Configuration
- Macro SPRITE_CLAMP_EN.
  - Defined: at shadow write, a row > 1199 is stored as 1199 and a col > 1599 is stored as 1599 (visible-area clamp).
  - Undefined: coordinates are stored verbatim. The full 11/12-bit range passes through unchanged.

## Test plan
- Reset: assert rst 2 cycles -> all sprite_row/col = 0, req_ready = 0, frame_count = 0, overrun = 0, bad_id = 0.
- Write id 1 = (row 300, col 800) -> sprite_row[1] stays 0 until vblank_start; then it is 300/800 at v+3. commit_done is high at v+SPRITES+1 (v+5 for SPRITES=4) and frame_count = 1.
- Both requesters valid for 4 cycles with rr_ptr = 0 -> grants alternate 0,1,0,1. A second write to id 2 (row 10 then row 20) -> after commit, row = 20.
- vblank_start in a cycle where req_valid[0] = 1 -> req_ready = 0 for 5 cycles (SPRITES = 4). The grant lands in the first IDLE cycle, and its data shows only after the following frame's commit.
- vblank_start pulsed again at v+2 -> overrun = 1, commit still ends at v+4. A write to id 7 with SPRITES = 4 -> bad_id = 1 and no active change.
- With SPRITE_CLAMP_EN, write (row 1500, col 4000) -> after commit, row = 1199, col = 1599. Without the macro -> row = 1500, col = 4000.
